// File: rtl/fir_pkg.sv
// Shared constants, default coefficient set and update FSM states
// for the 33-tap FIR slice.
package fir_pkg;

    localparam int TAPS  = 33;
    localparam int CW    = 16;
    localparam int AW    = 6;
    localparam int DIV   = 20;
    localparam int CNT_W = $clog2(DIV);

    typedef logic [CW-1:0] coeff_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ARMED
    } upd_state_t;

    // Symmetric low-pass set; centre tap is index 16.
    localparam coeff_t DEFAULT_COEFF [TAPS] = '{
        16'h0003, 16'h0000, 16'h0065, 16'h006E,
        16'h0000, 16'h03F2, 16'h000D, 16'h0000,
        16'h0013, 16'h0018, 16'h0000, 16'h0025,
        16'h0030, 16'h0000, 16'h0066, 16'h00CE,
        16'h01F4,
        16'h00CE, 16'h0066, 16'h0000, 16'h0030,
        16'h0025, 16'h0000, 16'h0018, 16'h0013,
        16'h0000, 16'h000D, 16'h03F2, 16'h0000,
        16'h006E, 16'h0065, 16'h0000, 16'h0003
    };

    function automatic logic addr_ok(input logic [AW-1:0] addr);
        return addr < AW'(TAPS);
    endfunction

endpackage

// File: rtl/fir_coeff_ctrl_if.sv
// Host-side coefficient update port of the FIR controller.
// master = register block, slave = coefficient controller.
interface fir_coeff_ctrl_if;
    import fir_pkg::*;

    logic          iCoeffUpdReq;
    logic          iCoeffWrEn;
    logic [AW-1:0] iCoeffWrAddr;
    logic [CW-1:0] iCoeffWrData;
    logic          iCoeffUpdDone;
    logic          oCoeffUpdBusy;
    logic          oCoeffErr;

    modport master (
        output iCoeffUpdReq,
        output iCoeffWrEn,
        output iCoeffWrAddr,
        output iCoeffWrData,
        output iCoeffUpdDone,
        input  oCoeffUpdBusy,
        input  oCoeffErr
    );

    modport slave (
        input  iCoeffUpdReq,
        input  iCoeffWrEn,
        input  iCoeffWrAddr,
        input  iCoeffWrData,
        input  iCoeffUpdDone,
        output oCoeffUpdBusy,
        output oCoeffErr
    );

endinterface

// File: rtl/fir_sample_tick.sv
// Divides the system clock by DIV into a registered one-cycle
// sample strobe; the count freezes while en is low.
module fir_sample_tick
    import fir_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    logic [CNT_W-1:0] cnt;
    logic             wrap;

    assign wrap = en && (cnt == CNT_W'(DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= wrap;
            if (wrap) begin
                cnt <= '0;
            end else if (en) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fir_coeff_ctrl.sv
// FIR sequencer: sample strobe, active coefficient bank and a
// shadow bank committed atomically on a sample boundary.
module fir_coeff_ctrl
    import fir_pkg::*;
(
    input  logic                 iClk_12MHz,
    input  logic                 iRsn,
    input  logic                 iEnFir,
    fir_coeff_ctrl_if.slave      host,
    output logic                 oEnSample_600kHz,
    output logic [TAPS*CW-1:0]   oCoeffFlat,
    output logic                 oCoeffSwapped
);

    upd_state_t    state;
    upd_state_t    state_nxt;
    coeff_t        active [TAPS];
    coeff_t        shadow [TAPS];

    logic          req;
    logic          wr;
    logic          done;
    logic [AW-1:0] addr;
    coeff_t        data;

    logic          req_ok;
    logic          wr_hit;
    logic          swap;
    logic          err_set;
    logic          err;

    assign req  = host.iCoeffUpdReq;
    assign wr   = host.iCoeffWrEn;
    assign done = host.iCoeffUpdDone;
    assign addr = host.iCoeffWrAddr;
    assign data = host.iCoeffWrData;

    fir_sample_tick u_tick (
        .clk   (iClk_12MHz),
        .rst_n (iRsn),
        .en    (iEnFir),
        .tick  (oEnSample_600kHz)
    );

    always_ff @(posedge iClk_12MHz) begin
        if (!iRsn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Any request that does not fit the current state is dropped
    // and only raises the sticky error.
    always_comb begin
        state_nxt = state;
        req_ok    = 1'b0;
        wr_hit    = 1'b0;
        swap      = 1'b0;
        err_set   = 1'b0;
        unique case (state)
            IDLE: begin
                req_ok  = req;
                err_set = wr || done;
                if (req) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                wr_hit  = wr && addr_ok(addr);
                err_set = req || (wr && !addr_ok(addr));
                if (done) begin
                    state_nxt = ARMED;
                end
            end
            ARMED: begin
                swap    = !iEnFir || oEnSample_600kHz;
                err_set = req || wr || done;
                if (swap) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk_12MHz) begin
        if (!iRsn) begin
            for (int k = 0; k < TAPS; k++) begin
                active[k] <= DEFAULT_COEFF[k];
                shadow[k] <= DEFAULT_COEFF[k];
            end
            oCoeffSwapped <= 1'b0;
            err           <= 1'b0;
        end else begin
            oCoeffSwapped <= swap;
            if (req_ok) begin
                shadow <= active;
            end
            if (wr_hit) begin
                shadow[addr] <= data;
            end
            if (swap) begin
                active <= shadow;
            end
            // A new error in the same cycle beats the clear.
            if (err_set) begin
                err <= 1'b1;
            end else if (req_ok) begin
                err <= 1'b0;
            end
        end
    end

    for (genvar k = 0; k < TAPS; k++) begin : g_flat
        assign oCoeffFlat[CW*k +: CW] = active[k];
    end

    assign host.oCoeffUpdBusy = (state != IDLE);
    assign host.oCoeffErr     = err;

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// Scoreboard bench for fir_coeff_ctrl: directed scenarios plus
// randomized traffic against a behavioural session model.
module tb_fir_coeff_ctrl;
    import fir_pkg::*;

    localparam int FW = TAPS * CW;

    logic          clk = 1'b0;
    logic          rstn;
    logic          en;
    logic          strobe;
    logic          swapped;
    logic [FW-1:0] flat;

    fir_coeff_ctrl_if bus ();

    fir_coeff_ctrl dut (
        .iClk_12MHz       (clk),
        .iRsn             (rstn),
        .iEnFir           (en),
        .host             (bus),
        .oEnSample_600kHz (strobe),
        .oCoeffFlat       (flat),
        .oCoeffSwapped    (swapped)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic          busy;
        logic          err;
        logic [FW-1:0] flat;
    } status_t;

    typedef struct {
        int            cyc;
        logic [FW-1:0] flat;
    } swap_t;

    status_t st_q[$];
    int      strobe_q[$];
    swap_t   swap_q[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int cur      = -1;
    bit started  = 1'b0;
    int strobe_cnt    = 0;
    int swap_cnt      = 0;
    int last_strobe   = -1;
    int last_swap     = -1;

    logic [CW-1:0] half [17] = '{
        16'h0003, 16'h0000, 16'h0065, 16'h006E,
        16'h0000, 16'h03F2, 16'h000D, 16'h0000,
        16'h0013, 16'h0018, 16'h0000, 16'h0025,
        16'h0030, 16'h0000, 16'h0066, 16'h00CE,
        16'h01F4
    };

    // Session model: 0 = no session, 1 = collecting writes,
    // 2 = waiting for a sample boundary to commit.
    int            m_mode;
    logic [CW-1:0] m_active [TAPS];
    logic [CW-1:0] m_shadow [TAPS];
    bit            m_err;
    bit            m_strobe;
    int            m_edges;

    function automatic logic [CW-1:0] dflt(int k);
        return (k < 17) ? half[k] : half[TAPS - 1 - k];
    endfunction

    function automatic logic [FW-1:0] model_flat();
        logic [FW-1:0] r;
        r = '0;
        for (int k = 0; k < TAPS; k++) r[CW*k +: CW] = m_active[k];
        return r;
    endfunction

    function automatic logic [CW-1:0] coeff(int k);
        return flat[CW*k +: CW];
    endfunction

    task automatic chk(string name, logic [FW-1:0] act,
                       logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode   = 0;
        m_err    = 1'b0;
        m_strobe = 1'b0;
        m_edges  = 0;
        for (int k = 0; k < TAPS; k++) begin
            m_active[k] = dflt(k);
            m_shadow[k] = dflt(k);
        end
    endtask

    task automatic step(bit rs, bit e, bit rq, bit we, int a,
                        logic [CW-1:0] d, bit dn);
        bit      err_set;
        bit      sw;
        bit      was_strobe;
        status_t s;
        swap_t   w;
        rstn              = rs;
        en                = e;
        bus.iCoeffUpdReq  = rq;
        bus.iCoeffWrEn    = we;
        bus.iCoeffWrAddr  = AW'(a);
        bus.iCoeffWrData  = d;
        bus.iCoeffUpdDone = dn;
        sw = 1'b0;
        if (!rs) begin
            model_reset();
        end else begin
            was_strobe = m_strobe;
            err_set = (we && (m_mode != 1 || a >= TAPS))
                   || (rq && m_mode != 0)
                   || (dn && m_mode != 1);
            if (m_mode == 0) begin
                if (rq) begin
                    m_shadow = m_active;
                    m_mode   = 1;
                    m_err    = 1'b0;
                end
            end else if (m_mode == 1) begin
                if (we && a < TAPS) m_shadow[a] = d;
                if (dn) m_mode = 2;
            end else if (!e || was_strobe) begin
                m_active = m_shadow;
                sw       = 1'b1;
                m_mode   = 0;
            end
            if (err_set) m_err = 1'b1;
            if (e) begin
                m_edges++;
                m_strobe = (m_edges % DIV == 0);
            end else begin
                m_strobe = 1'b0;
            end
        end
        s.cyc  = cyc;
        s.busy = (m_mode != 0);
        s.err  = m_err;
        s.flat = model_flat();
        st_q.push_back(s);
        if (m_strobe) strobe_q.push_back(cyc);
        if (sw) begin
            w.cyc  = cyc;
            w.flat = model_flat();
            swap_q.push_back(w);
        end
        @(posedge clk);
        #1;
        cur = cyc;
        cyc++;
        started = 1'b1;
    endtask

    task automatic idle(int n, bit e);
        repeat (n) step(1'b1, e, 1'b0, 1'b0, 0, '0, 1'b0);
    endtask

    always @(negedge clk) begin : monitor
        status_t s;
        swap_t   w;
        bit      exp_st;
        bit      exp_sw;
        if (started) begin
            if (st_q.size() == 0 || st_q[0].cyc != cur) begin
                checks++;
                failures++;
                $display("FAIL status_seq: cycle %0d has no expectation",
                         cur);
            end else begin
                s = st_q.pop_front();
                chk("busy", bus.oCoeffUpdBusy, s.busy);
                chk("err", bus.oCoeffErr, s.err);
                chk("flat", flat, s.flat);
            end
            exp_st = strobe_q.size() > 0 && strobe_q[0] == cur;
            if (strobe) begin
                strobe_cnt++;
                last_strobe = cur;
            end
            if (exp_st || strobe) begin
                chk("strobe", strobe, exp_st);
                if (exp_st) void'(strobe_q.pop_front());
            end
            exp_sw = swap_q.size() > 0 && swap_q[0].cyc == cur;
            if (swapped) begin
                swap_cnt++;
                last_swap = cur;
            end
            if (exp_sw || swapped) begin
                chk("swapped", swapped, exp_sw);
                if (exp_sw) begin
                    w = swap_q.pop_front();
                    chk("swap_flat", flat, w.flat);
                end
            end
        end
    end

    initial begin
        int base;
        int n0;
        int d;
        bit rs;
        bit e;

        // Power-up, 60 enabled cycles
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, '0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, '0, 1'b0);
        n0 = strobe_cnt;
        idle(60, 1'b1);
        chk("s1_c0", coeff(0), 16'h0003);
        chk("s1_c16", coeff(16), 16'h01F4);
        chk("s1_c32", coeff(32), 16'h0003);
        chk("s1_err", bus.oCoeffErr, 1'b0);
        chk("s1_busy", bus.oCoeffUpdBusy, 1'b0);
        idle(1, 1'b0);
        chk("s1_strobes", strobe_cnt - n0, 3);

        // Single-tap update committed on the cycle-39 strobe
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, '0, 1'b0);
        base = cyc;
        idle(1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 0, '0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 16, 16'h0100, 1'b0);
        idle(22, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 0, '0, 1'b1);
        idle(16, 1'b1);
        chk("s2_swap_cyc", last_swap - base, 40);
        chk("s2_c16", coeff(16), 16'h0100);
        chk("s2_c15", coeff(15), 16'h00CE);
        chk("s2_c17", coeff(17), 16'h00CE);

        // Out-of-range address, sticky error, clear on next request
        step(1'b1, 1'b1, 1'b1, 1'b0, 0, '0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 40, 16'h1234, 1'b0);
        idle(2, 1'b1);
        chk("s3_err_set", bus.oCoeffErr, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 0, '0, 1'b1);
        idle(25, 1'b1);
        chk("s3_err_held", bus.oCoeffErr, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 0, '0, 1'b0);
        chk("s3_err_clr", bus.oCoeffErr, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 0, '0, 1'b1);
        idle(25, 1'b1);

        // Write in IDLE, then request while ARMED
        step(1'b1, 1'b1, 1'b0, 1'b1, 3, 16'hBEEF, 1'b0);
        chk("s4_idle_wr_err", bus.oCoeffErr, 1'b1);
        chk("s4_idle_busy", bus.oCoeffUpdBusy, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 0, '0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 0, '0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 0, '0, 1'b0);
        chk("s4_armed_req_err", bus.oCoeffErr, 1'b1);
        idle(25, 1'b1);

        // Divider freeze, then commit with the filter stopped
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, '0, 1'b0);
        base = cyc;
        idle(10, 1'b1);
        idle(7, 1'b0);
        idle(14, 1'b1);
        chk("s5_strobe_cyc", last_strobe - base, 26);
        step(1'b1, 1'b0, 1'b1, 1'b0, 0, '0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 5, 16'h0A0A, 1'b0);
        d = cyc;
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, '0, 1'b1);
        idle(3, 1'b0);
        chk("s5_swap_cyc", last_swap, d + 1);
        chk("s5_c5", coeff(5), 16'h0A0A);

        // Reset while ARMED discards the session
        step(1'b1, 1'b1, 1'b1, 1'b0, 0, '0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 0, 16'h7FFF, 1'b1);
        idle(2, 1'b1);
        n0 = swap_cnt;
        step(1'b0, 1'b1, 1'b0, 1'b0, 0, '0, 1'b0);
        chk("s6_c0", coeff(0), 16'h0003);
        chk("s6_busy", bus.oCoeffUpdBusy, 1'b0);
        idle(30, 1'b1);
        chk("s6_no_swap", swap_cnt - n0, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rs = ($urandom_range(0, 499) != 0);
            e  = ($urandom_range(0, 9) != 0);
            step(rs, e,
                 $urandom_range(0, 29) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 40),
                 CW'($urandom),
                 $urandom_range(0, 29) == 0);
        end
        idle(3, 1'b1);
        @(negedge clk);
        #1;
        chk("strobe_q_empty", strobe_q.size(), 0);
        chk("swap_q_empty", swap_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fir_coeff_ctrl.md
# fir_coeff_ctrl

Controller that sequences the 33-tap FIR datapath. It divides the 12 MHz system clock into the 600 kHz sample-enable strobe. It owns the active coefficient bank driven into the filter and accepts host coefficient updates into a shadow bank. The shadow bank is committed atomically on a sample boundary, so the filter never computes with a half-written coefficient set. It sits between the host register interface and the FIR filter instance.

## Interface
Parameters:
- TAPS, 33, number of coefficients
- CW, 16, coefficient width (two's complement)
- AW, 6, coefficient address width
- DIV, 20, clocks per sample (12 MHz / 600 kHz)

Ports:
- iClk_12MHz  in  1  sole clock; all logic on rising edge
- iRsn  in  1  reset; synchronous, active-low
- iEnFir  in  1  run enable; low freezes sample divider
- iCoeffUpdReq  in  1  host pulse: open an update session
- iCoeffWrEn  in  1  shadow write strobe
- iCoeffWrAddr  in  AW  shadow write address, 0..TAPS-1
- iCoeffWrData  in  CW  shadow write data
- iCoeffUpdDone  in  1  host pulse: commit session
- oEnSample_600kHz  out  1  one-cycle sample strobe, period DIV
- oCoeffFlat  out  TAPS*CW  active bank; coeff[k] at bits [CW*k+CW-1 : CW*k]
- oCoeffSwapped  out  1  one-cycle pulse, active bank just updated
- oCoeffUpdBusy  out  1  high while state != IDLE
- oCoeffErr  out  1  sticky protocol error

## Operation
- Reset state (iRsn=0 at an edge):
  - state=IDLE, divider cnt=0.
  - oEnSample_600kHz=0, oCoeffSwapped=0, oCoeffUpdBusy=0, oCoeffErr=0.
  - Active and shadow banks load DEFAULT_COEFF: 0x0003, 0x0000, 0x0065, 0x006E, 0x0000, 0x03F2, 0x000D, 0x0000, 0x0013, 0x0018, 0x0000, 0x0025, 0x0030, 0x0000, 0x0066, 0x00CE, 0x01F4, then mirrored (symmetric, 33 entries).
- Divider:
  - cnt advances by 1 per cycle while iEnFir=1 and wraps DIV-1 -> 0.
  - cnt holds while iEnFir=0.
  - oEnSample_600kHz is registered; it is high for exactly one cycle each time cnt wraps.
- FSM states: IDLE, LOAD, ARMED.
  - IDLE -> LOAD on iCoeffUpdReq. On the same edge, shadow <= active (partial updates allowed) and oCoeffErr clears.
  - LOAD: an iCoeffWrEn with addr < TAPS writes shadow[addr]. iCoeffUpdDone -> ARMED.
  - ARMED:
    - If iEnFir=1: on the edge at which oEnSample_600kHz is sampled high, active <= shadow, then -> IDLE.
    - If iEnFir=0: swap on the next edge, then -> IDLE.
  - oCoeffSwapped is high the cycle after the swap edge, the same cycle the new oCoeffFlat is first visible.
- Errors (set oCoeffErr; the offending request is ignored):
  - iCoeffWrEn outside LOAD.
  - Address >= TAPS.
  - iCoeffUpdReq outside IDLE.
  - iCoeffUpdDone outside LOAD.
- Error clear: oCoeffErr clears only on an accepted iCoeffUpdReq. A set condition in the same cycle wins over the clear.
- Simultaneous events:
  - iCoeffWrEn with iCoeffUpdDone in LOAD: the write lands, then the commit includes it.
  - iCoeffUpdReq with iCoeffWrEn in IDLE: the request is accepted, the write is ignored, err=1.
- Reset mid-session: the update is discarded, active returns to DEFAULT_COEFF, and no oCoeffSwapped pulse occurs.

## Timing
- With iEnFir high from the first post-reset edge (cycle 0), the strobe is high in cycles 19, 39, 59, …
- iEnFir low for N cycles delays subsequent strobes by exactly N cycles.
- The filter consuming a strobe at edge E uses the old coefficients. The sample at the next strobe (E+DIV) uses the new ones.
- Worst-case commit latency from iCoeffUpdDone to oCoeffSwapped: DIV+1 cycles with iEnFir=1; 2 cycles with iEnFir=0.
- Request/done strobes are single-cycle pulses. Holding them high for several cycles raises the error flag on the later cycles.

## Structure
- Package fir_pkg holds:
  - TAPS, CW, AW, DIV constants.
  - DEFAULT_COEFF array.
  - FSM state enum (IDLE/LOAD/ARMED).
  - Shared with the FIR filter and the testbench.
- Sub-module fir_sample_tick: the DIV counter and registered strobe, with enable input.
- The FSM and both banks live in fir_coeff_ctrl.

## Test plan
- Reset, iEnFir=1 for 60 cycles -> strobe exactly in cycles 19, 39, 59; oCoeffFlat[15:0]=0x0003, coeff[16]=0x01F4; all flags 0.
- Req, write addr 16 = 0x0100, done at cycle 25 -> oCoeffFlat unchanged through cycle 39 strobe; oCoeffSwapped pulse in cycle 40; coeff[16]=0x0100; other taps unchanged.
- Write addr 40 in LOAD -> ignored, oCoeffErr=1 and held; next accepted req -> oCoeffErr=0.
- iCoeffWrEn in IDLE, and req while ARMED -> oCoeffErr=1; banks and state unchanged.
- iEnFir=0 for 7 cycles starting at cycle 10 -> next strobe at cycle 26; done issued while iEnFir=0 -> swap pulse 2 cycles later.
- Reset asserted in ARMED after writing coeff[0]=0x7FFF -> coeff[0]=0x0003, busy=0, no swap pulse.
